// File: rtl/fu_completion_arbiter.sv
// rtl/fu_completion_arbiter.sv - per-FU completion tracking and writeback arbitration toward the ROB.
// Define FU_ARB_RR_EN for round-robin arbitration; default is fixed priority, highest slot index first.
module fu_completion_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int FU_IDX_W   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int DEST_WIDTH = 3,
  parameter int CTRL_WIDTH = 6,
  parameter int LAT_WIDTH  = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  input  logic [FU_IDX_W-1:0]          issue_fu_i,
  input  logic [LAT_WIDTH-1:0]         issue_latency_i,
  input  logic [ROB_WIDTH-1:0]         issue_rob_i,
  input  logic [DEST_WIDTH-1:0]        issue_dest_i,
  input  logic [CTRL_WIDTH-1:0]        issue_ctrl_i,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result_i,
  output logic [NUM_FU-1:0]            fu_capture_o,
  output logic [NUM_FU-1:0]            fu_free_o,
  output logic                         issue_err_o,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output logic [DATA_WIDTH-1:0]        wb_data_o,
  output logic [ROB_WIDTH-1:0]         wb_rob_o,
  output logic [DEST_WIDTH-1:0]        wb_dest_o,
  output logic [CTRL_WIDTH-1:0]        wb_ctrl_o,
  output logic [FU_IDX_W-1:0]          wb_fu_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} slot_state_e;

  slot_state_e           state_q [NUM_FU];
  logic [LAT_WIDTH-1:0]  cnt_q   [NUM_FU];
  logic [DATA_WIDTH-1:0] data_q  [NUM_FU];
  logic [ROB_WIDTH-1:0]  rob_q   [NUM_FU];
  logic [DEST_WIDTH-1:0] dest_q  [NUM_FU];
  logic [CTRL_WIDTH-1:0] ctrl_q  [NUM_FU];
  logic                  issue_err_q;
  logic                  issue_err_d;

  logic [NUM_FU-1:0]     done_vec;
  logic [NUM_FU-1:0]     grant_vec;
  logic [NUM_FU-1:0]     accept_vec;
  logic                  sel_found;
  logic [FU_IDX_W-1:0]   sel_idx;
  logic                  grant;
  logic [LAT_WIDTH-1:0]  load_lat;

`ifdef FU_ARB_RR_EN
  logic [FU_IDX_W-1:0]   ptr_q;
  logic [FU_IDX_W-1:0]   ptr_d;
  logic                  hold_q;
  logic [FU_IDX_W-1:0]   hold_idx_q;
`endif

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      done_vec[i]     = (state_q[i] == S_DONE);
      fu_capture_o[i] = (state_q[i] == S_BUSY) && (cnt_q[i] == LAT_WIDTH'(1)) && !flush_i;
    end
  end

  // DONE slots only leave on grant or flush, so the choice stays put under back-pressure
  // unless a newly finished slot outranks it.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef FU_ARB_RR_EN
    if (hold_q) begin
      sel_found = 1'b1;
      sel_idx   = hold_idx_q;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        for (int i = 0; i < NUM_FU; i++) begin
          if (!sel_found && done_vec[i] && (((i + NUM_FU - int'(ptr_q)) % NUM_FU) == k)) begin
            sel_found = 1'b1;
            sel_idx   = FU_IDX_W'(i);
          end
        end
      end
    end
`else
    for (int i = 0; i < NUM_FU; i++) begin
      if (done_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = FU_IDX_W'(i);
      end
    end
`endif
  end

  assign wb_valid_o = sel_found && !flush_i;
  assign grant      = wb_valid_o && wb_ready_i;
  assign load_lat   = (issue_latency_i == '0) ? LAT_WIDTH'(1) : issue_latency_i;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      grant_vec[i]  = grant && (sel_idx == FU_IDX_W'(i));
      fu_free_o[i]  = (state_q[i] == S_IDLE) || grant_vec[i];
      accept_vec[i] = issue_valid_i && !flush_i && (issue_fu_i == FU_IDX_W'(i)) && fu_free_o[i];
    end
    issue_err_d = issue_valid_i && !flush_i && !(|accept_vec);
  end

  always_comb begin
    wb_data_o = '0;
    wb_rob_o  = '0;
    wb_dest_o = '0;
    wb_ctrl_o = '0;
    wb_fu_o   = '0;
    if (wb_valid_o) begin
      wb_fu_o = sel_idx;
      for (int i = 0; i < NUM_FU; i++) begin
        if (sel_idx == FU_IDX_W'(i)) begin
          wb_data_o = data_q[i];
          wb_rob_o  = rob_q[i];
          wb_dest_o = dest_q[i];
          wb_ctrl_o = ctrl_q[i];
        end
      end
    end
  end

  assign issue_err_o = issue_err_q;

`ifdef FU_ARB_RR_EN
  assign ptr_d = FU_IDX_W'((int'(sel_idx) + 1) % NUM_FU);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      if (grant) ptr_q <= ptr_d;
      hold_q     <= wb_valid_o && !wb_ready_i;
      hold_idx_q <= sel_idx;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_err_q <= 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        data_q[i]  <= '0;
        rob_q[i]   <= '0;
        dest_q[i]  <= '0;
        ctrl_q[i]  <= '0;
      end
    end else begin
      issue_err_q <= issue_err_d;
      for (int i = 0; i < NUM_FU; i++) begin
        if (flush_i) begin
          state_q[i] <= S_IDLE;
          cnt_q[i]   <= '0;
        end else if (accept_vec[i]) begin
          state_q[i] <= S_BUSY;
          cnt_q[i]   <= load_lat;
          rob_q[i]   <= issue_rob_i;
          dest_q[i]  <= issue_dest_i;
          ctrl_q[i]  <= issue_ctrl_i;
        end else begin
          case (state_q[i])
            S_BUSY: begin
              if (cnt_q[i] == LAT_WIDTH'(1)) begin
                state_q[i] <= S_DONE;
                cnt_q[i]   <= '0;
                data_q[i]  <= fu_result_i[i*DATA_WIDTH +: DATA_WIDTH];
              end else begin
                cnt_q[i] <= cnt_q[i] - LAT_WIDTH'(1);
              end
            end
            S_DONE: begin
              if (grant_vec[i]) state_q[i] <= S_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fu_completion_arbiter.sv
// tb/tb_fu_completion_arbiter.sv - self-checking bench for fu_completion_arbiter (honours FU_ARB_RR_EN).
module tb_fu_completion_arbiter;
  localparam int NF = 4, IW = 3, DW = 32, RW = 4, DSW = 3, CW = 6, LW = 5;

  logic clk = 1'b0, rst_n = 1'b0, fl = 1'b0, iv = 1'b0, rdy = 1'b0;
  logic [IW-1:0]  ifu = '0;
  logic [LW-1:0]  ilat = '0;
  logic [RW-1:0]  irob = '0;
  logic [DSW-1:0] idest = '0;
  logic [CW-1:0]  ictrl = '0;
  logic [NF*DW-1:0] res = '0;
  logic [NF-1:0]  cap, free;
  logic           err, wv;
  logic [DW-1:0]  wd;
  logic [RW-1:0]  wr;
  logic [DSW-1:0] wdst;
  logic [CW-1:0]  wc;
  logic [IW-1:0]  wf;

  fu_completion_arbiter #(
    .NUM_FU(NF), .FU_IDX_W(IW), .DATA_WIDTH(DW), .ROB_WIDTH(RW),
    .DEST_WIDTH(DSW), .CTRL_WIDTH(CW), .LAT_WIDTH(LW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl), .issue_valid_i(iv), .issue_fu_i(ifu),
    .issue_latency_i(ilat), .issue_rob_i(irob), .issue_dest_i(idest), .issue_ctrl_i(ictrl),
    .fu_result_i(res), .fu_capture_o(cap), .fu_free_o(free), .issue_err_o(err),
    .wb_valid_o(wv), .wb_ready_i(rdy), .wb_data_o(wd), .wb_rob_o(wr), .wb_dest_o(wdst),
    .wb_ctrl_o(wc), .wb_fu_o(wf)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference: each in-flight op is described by the absolute cycle at which it becomes DONE.
  bit             m_act   [NF];
  int             m_ready [NF];
  logic [DW-1:0]  m_data  [NF];
  logic [RW-1:0]  m_rob   [NF];
  logic [DSW-1:0] m_dest  [NF];
  logic [CW-1:0]  m_ctrl  [NF];
  int  now;
  bit  m_err;
  int  m_ptr;
  bit  m_hold;
  int  m_hold_idx;

  typedef struct {
    logic iv; int fu; int lat; int rob; logic rdy;
    logic e_valid; int e_fu; int e_rob; logic [31:0] e_data; logic e_err; logic [3:0] e_free;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_act[i] = 0; m_ready[i] = 0; m_data[i] = '0;
      m_rob[i] = '0; m_dest[i] = '0; m_ctrl[i] = '0;
    end
    now = 0; m_err = 0; m_ptr = 0; m_hold = 0; m_hold_idx = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; iv = 1'b0; fl = 1'b0; rdy = 1'b0;
    #1;
    chk("rst_free", free, 4'b1111);
    chk("rst_valid", wv, 0);
    chk("rst_err", err, 0);
    chk("rst_capture", cap, 0);
    chk("rst_data", wd, 0);
    chk("rst_fu", wf, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic v, input int f, input int l, input int r, input logic rd);
    iv = v; ifu = IW'(f); ilat = LW'(l); irob = RW'(r);
    idest = DSW'(f); ictrl = CW'(r * 3); rdy = rd; fl = 1'b0;
  endtask

  task automatic step();
    int sel;
    logic [NF-1:0] done, e_free, e_cap;
    logic e_valid, grant, acc;
    #1;
    sel = -1;
    for (int i = 0; i < NF; i++) done[i] = m_act[i] && (now >= m_ready[i]);
`ifdef FU_ARB_RR_EN
    if (m_hold) sel = m_hold_idx;
    else for (int k = 0; k < NF; k++) begin
      int j;
      j = (m_ptr + k) % NF;
      if (sel < 0 && done[j]) sel = j;
    end
`else
    for (int i = 0; i < NF; i++) if (done[i]) sel = i;
`endif
    e_valid = (sel >= 0) && !fl;
    grant = e_valid && rdy;
    acc = 1'b0;
    for (int i = 0; i < NF; i++) begin
      e_free[i] = !m_act[i] || (grant && sel == i);
      e_cap[i]  = m_act[i] && (now == m_ready[i] - 1) && !fl;
    end
    for (int i = 0; i < NF; i++) if (iv && !fl && int'(ifu) == i && e_free[i]) acc = 1'b1;
    chk("fu_capture", cap, e_cap);
    chk("fu_free", free, e_free);
    chk("issue_err", err, m_err);
    chk("wb_valid", wv, e_valid);
    if (e_valid) begin
      chk("wb_data", wd, m_data[sel]);
      chk("wb_rob", wr, m_rob[sel]);
      chk("wb_dest", wdst, m_dest[sel]);
      chk("wb_ctrl", wc, m_ctrl[sel]);
      chk("wb_fu", wf, sel);
    end else begin
      chk("wb_zero", {wd, wr, wdst, wc, wf}, 0);
    end
    if (fl) begin
      for (int i = 0; i < NF; i++) m_act[i] = 0;
      m_err = 0; m_hold = 0;
    end else begin
      for (int i = 0; i < NF; i++) if (e_cap[i]) m_data[i] = res[i*DW +: DW];
      if (grant) begin
        m_act[sel] = 0;
        m_ptr = (sel + 1) % NF;
      end
      m_hold = e_valid && !rdy;
      m_hold_idx = sel;
      if (acc) begin
        m_act[ifu] = 1;
        m_ready[ifu] = now + 1 + ((ilat == 0) ? 1 : int'(ilat));
        m_rob[ifu] = irob; m_dest[ifu] = idest; m_ctrl[ifu] = ictrl;
      end
      m_err = iv && !acc;
    end
    now++;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input int v, input int f, input int l, input int r, input int rd,
                              input int ev, input int ef, input int er, input logic [31:0] ed,
                              input int ee, input logic [3:0] efr);
    vec_t t;
    t.iv = v[0]; t.fu = f; t.lat = l; t.rob = r; t.rdy = rd[0];
    t.e_valid = ev[0]; t.e_fu = ef; t.e_rob = er; t.e_data = ed; t.e_err = ee[0]; t.e_free = efr;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int first, second;
    tbl[0] = mk(1, 0, 3, 4'hA, 1, 0, 0, 0, 32'h0, 0, 4'b1111);
    tbl[1] = mk(1, 1, 2, 4'h5, 1, 0, 0, 0, 32'h0, 0, 4'b1110);
    tbl[2] = mk(1, 1, 1, 4'h7, 1, 0, 0, 0, 32'h0, 0, 4'b1100);
    tbl[3] = mk(1, 5, 1, 4'h7, 1, 0, 0, 0, 32'h0, 1, 4'b1100);
`ifdef FU_ARB_RR_EN
    tbl[4] = mk(0, 0, 0, 0, 0, 1, 0, 4'hA, 32'h1234, 1, 4'b1100);
    tbl[5] = mk(0, 0, 0, 0, 1, 1, 0, 4'hA, 32'h1234, 0, 4'b1101);
    tbl[6] = mk(0, 0, 0, 0, 1, 1, 1, 4'h5, 32'h2222, 0, 4'b1111);
`else
    tbl[4] = mk(0, 0, 0, 0, 0, 1, 1, 4'h5, 32'h2222, 1, 4'b1100);
    tbl[5] = mk(0, 0, 0, 0, 1, 1, 1, 4'h5, 32'h2222, 0, 4'b1110);
    tbl[6] = mk(0, 0, 0, 0, 1, 1, 0, 4'hA, 32'h1234, 0, 4'b1111);
`endif
    tbl[7] = mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 4'b1111);

    @(negedge clk);
    do_reset();
    res = {32'h4444, 32'h3333, 32'h2222, 32'h1234};
    for (int v = 0; v < 8; v++) begin
      iv = tbl[v].iv; ifu = IW'(tbl[v].fu); ilat = LW'(tbl[v].lat); irob = RW'(tbl[v].rob);
      idest = '0; ictrl = '0; rdy = tbl[v].rdy; fl = 1'b0;
      #1;
      chk($sformatf("tbl%0d_valid", v), wv, tbl[v].e_valid);
      chk($sformatf("tbl%0d_fu", v), wf, tbl[v].e_fu);
      chk($sformatf("tbl%0d_rob", v), wr, tbl[v].e_rob);
      chk($sformatf("tbl%0d_data", v), wd, tbl[v].e_data);
      chk($sformatf("tbl%0d_err", v), err, tbl[v].e_err);
      chk($sformatf("tbl%0d_free", v), free, tbl[v].e_free);
      step();
    end

    // Back-pressure with slots 0 and 2 finished.
    do_reset();
`ifdef FU_ARB_RR_EN
    first = 0; second = 2;
`else
    first = 2; second = 0;
`endif
    drive(1, 0, 1, 1, 0); step();
    drive(1, 2, 1, 2, 0); step();
    drive(0, 0, 0, 0, 0); step();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 0);
      #1;
      chk("bp_hold_fu", wf, first);
      chk("bp_hold_free", free, 4'b1010);
      step();
    end
    drive(0, 0, 0, 0, 1);
    #1;
    chk("bp_grant1_fu", wf, first);
    chk("bp_grant1_free", free, 4'b1010 | (4'b0001 << first));
    step();
    #1;
    chk("bp_grant2_fu", wf, second);
    chk("bp_grant2_valid", wv, 1);
    step();
    #1;
    chk("bp_drained", wv, 0);
    step();

    // Same-cycle reuse of slot 3.
    do_reset();
    drive(1, 3, 1, 9, 0); step();
    drive(0, 0, 0, 0, 0); step();
    drive(1, 3, 2, 4'hC, 1);
    #1;
    chk("reuse_free3", free[3], 1);
    chk("reuse_fu", wf, 3);
    step();
    drive(0, 0, 0, 0, 1);
    #1;
    chk("reuse_err", err, 0);
    chk("reuse_gap", wv, 0);
    step();
    res[3*DW +: DW] = 32'hBEEF0003;
    #1;
    chk("reuse_capture", cap, 4'b1000);
    step();
    #1;
    chk("reuse_wb_valid", wv, 1);
    chk("reuse_wb_data", wd, 32'hBEEF0003);
    chk("reuse_wb_rob", wr, 4'hC);
    step();

    // Flush with mixed BUSY/DONE slots, then drain order with all four finishing together.
    do_reset();
    drive(1, 0, 1, 1, 0); step();
    drive(1, 1, 1, 2, 0); step();
    drive(1, 2, 6, 3, 0); step();
    drive(1, 3, 6, 4, 0); step();
    drive(1, 0, 1, 5, 0); fl = 1'b1;
    #1;
    chk("flush_valid_now", wv, 0);
    step();
    drive(1, 0, 4, 6, 0);
    #1;
    chk("flush_free", free, 4'b1111);
    chk("flush_valid", wv, 0);
    chk("flush_err", err, 0);
    step();
    drive(1, 1, 3, 7, 0); step();
    drive(1, 2, 2, 8, 0); step();
    drive(1, 3, 1, 9, 0); step();
    drive(0, 0, 0, 0, 0); step();
    for (int k = 0; k < NF; k++) begin
      drive(0, 0, 0, 0, 1);
      #1;
`ifdef FU_ARB_RR_EN
      chk($sformatf("order%0d_fu", k), wf, k);
`else
      chk($sformatf("order%0d_fu", k), wf, NF - 1 - k);
`endif
      chk($sformatf("order%0d_valid", k), wv, 1);
      step();
    end

    // Reset in the middle of a countdown.
    do_reset();
    drive(1, 1, 5, 3, 1); step();
    drive(0, 0, 0, 0, 1); step();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, 0, 1);
      #1;
      chk("midrst_no_wb", wv, 0);
      step();
    end

    // Random traffic against the reference.
    for (int n = 0; n < 3000; n++) begin
      iv = 1'($urandom_range(0, 1));
      ifu = IW'($urandom_range(0, 5));
      ilat = LW'($urandom_range(0, 6));
      irob = RW'($urandom);
      idest = DSW'($urandom);
      ictrl = CW'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 39) == 0);
      res = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    fl = 1'b0; iv = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fu_completion_arbiter.md
# fu_completion_arbiter

Parametrised completion tracker and writeback arbiter for the execute stage. It holds one in-flight slot per functional unit, counts each issued op down to its completion cycle, captures the unit's result, and arbitrates finished slots onto a single writeback port toward the ROB with a valid/ready handshake. This is the generalised successor to the fixed five-unit execute arbiter: N units, configurable widths, per-slot busy/done state, flush, back-pressure, and optional round-robin fairness.

## Interface
- NUM_FU, 4: number of functional-unit slots (≥2)
- FU_IDX_W, 2: width of unit index, ≥ clog2(NUM_FU)
- DATA_WIDTH, 32: result width
- ROB_WIDTH, 4: ROB entry tag width
- DEST_WIDTH, 3: destination register width
- CTRL_WIDTH, 6: control bundle width carried to writeback
- LAT_WIDTH, 5: latency field width

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- flush  in  1  synchronous; discard all in-flight and done ops
- issue_valid  in  1  issue request this cycle
- issue_fu  in  FU_IDX_W  target slot
- issue_latency  in  LAT_WIDTH  cycles until result is valid; 0 treated as 1
- issue_rob  in  ROB_WIDTH  ROB tag
- issue_dest  in  DEST_WIDTH  destination register
- issue_ctrl  in  CTRL_WIDTH  control bundle
- fu_result  in  NUM_FU*DATA_WIDTH  flat result bus, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
- fu_capture  out  NUM_FU  slot i samples its result this cycle
- fu_free  out  NUM_FU  slot i can accept an issue this cycle
- issue_err  out  1  registered pulse: last-cycle issue was rejected
- wb_valid  out  1  writeback entry presented
- wb_ready  in  1  downstream accepts
- wb_data  out  DATA_WIDTH  result
- wb_rob, wb_dest, wb_ctrl  out  ROB_WIDTH/DEST_WIDTH/CTRL_WIDTH  metadata of granted slot
- wb_fu  out  FU_IDX_W  index of granted slot

## Operation
- Per-slot FSM: IDLE -> BUSY on accepted issue; BUSY -> DONE when counter==1 (result captured into slot register); DONE -> IDLE on grant.
- Issue stores rob/dest/ctrl and loads counter with max(issue_latency,1). In BUSY, counter decrements every cycle.
- fu_capture[i] = BUSY && counter==1 (combinational); the unit must drive fu_result slice i valid in that cycle.
- fu_free[i] = IDLE, or DONE and granted this cycle (combinational). Issue is accepted iff issue_valid && issue_fu < NUM_FU && fu_free[issue_fu]; otherwise dropped, no state change, issue_err=1 next cycle.
- Issue into a slot granted the same cycle: grant completes, slot goes BUSY with new op.
- Arbitration among DONE slots; grant = wb_valid && wb_ready. When wb_valid=0 all wb_* data outputs are 0.
- wb_* are driven combinationally from the selected slot's registers; selection held stable while wb_valid && !wb_ready unless a higher-priority slot becomes DONE (fixed-priority mode only).
- flush: all slots -> IDLE, counters 0, wb_valid=0 and no grant that cycle, issue in the flush cycle ignored (no issue_err). flush wins over issue, capture and grant.
- Reset (any time, including mid-countdown): all slots IDLE, counters 0, slot registers 0, issue_err 0, round-robin pointer 0; all outputs 0 except fu_free = all ones.

## Timing
- Issue at edge t with latency L: fu_capture high during cycle t+L-1 (after edge t+L-1), result captured at edge t+L, wb_valid earliest in cycle after edge t+L.
- L=0 and L=1 behave identically.
- Grant at edge g frees slot; fu_free already high in cycle before edge g (same-cycle reuse).
- Max throughput: one writeback per cycle; per-slot issue rate one op per L+1 cycles when wb_ready stays high.

## Configuration
- FU_ARB_RR_EN defined: round-robin; search starts at slot after last granted index (pointer updates only on grant); a presented entry is held until granted.
- Undefined: fixed priority, highest index wins (complex/long-latency units drain first).

## Test plan
- Reset mid-operation: issue slot 1 L=5, assert reset low 2 cycles later -> fu_free=4'b1111, wb_valid=0, no later writeback.
- Single op: issue slot 0 L=3 rob=4'hA, fu_result slice0=32'h1234 during capture cycle -> wb_valid 3 cycles after issue edge, wb_data=32'h1234, wb_rob=4'hA, wb_fu=0.
- Back-pressure: slots 0 and 2 DONE, wb_ready=0 for 4 cycles -> wb outputs stable, no slot freed; wb_ready=1 -> two grants on consecutive cycles (slot 2 first without FU_ARB_RR_EN).
- Reject: issue slot 1 while BUSY -> issue_err pulse next cycle, original op completes unchanged; issue_fu=5 with NUM_FU=4 -> issue_err.
- Same-cycle reuse: slot 3 DONE granted while new issue to slot 3 L=2 -> both accepted, second result written back 2 cycles later.
- Flush: slots 0–3 BUSY/DONE, flush with issue_valid=1 -> next cycle all fu_free=1, wb_valid=0, issue_err=0; with FU_ARB_RR_EN, all four slots DONE and wb_ready=1 -> grants 0,1,2,3 in order.
